// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the M-extension multiply/divide scheduler.
//   - funct3 encodings of the eight M-extension ops
//   - scheduler FSM state encoding
//   - divide special-case result constants
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Quotient of a divide by zero, and the most negative signed value.
    localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN_DEF-1:0] INT_MIN   = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/md_special_case.sv
// md_special_case: combinational detection of divide cases that are resolved
// without running the iterative divider.
//   op             in  3     funct3 of the M-extension op
//   a, b           in  XLEN  operands
//   is_special     out 1     op is a div/rem and the result is known now
//   special_result out XLEN  result for the special case (0 otherwise)
module md_special_case
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            is_special,
    output logic [XLEN-1:0] special_result
);

    logic w_div_by_zero;
    logic w_overflow;
    logic w_is_rem;

    assign w_is_rem      = op[1];
    assign w_div_by_zero = (b == '0);
    // Only the signed forms can overflow: INT_MIN / -1.
    assign w_overflow    = ((op == OP_DIV) || (op == OP_REM)) &&
                           (a == INT_MIN) && (b == '1);

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (op[2]) begin
            if (w_div_by_zero) begin
                is_special     = 1'b1;
                special_result = w_is_rem ? a : DIV0_QUOT;
            end else if (w_overflow) begin
                is_special     = 1'b1;
                special_result = w_is_rem ? '0 : INT_MIN;
            end
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: EX-stage scheduler for the M-extension multiplier/divider.
// Accepts one op in IDLE, captures operands, runs either the fixed-latency
// multiplier or the handshake divider (or resolves a divide special case
// immediately), stalls EX meanwhile and holds the result while EX is held.
//   clk, rst               clock, asynchronous active-high reset
//   stall[5:0]             pipeline stall vector; bit 2 = EX held
//   flush                  kill in-flight op
//   ex_valid, op, a, b     M-extension op presented by EX
//   mul_start, mul_*_signed, mul_result     multiplier interface
//   div_start, div_signed, div_done, div_quot, div_rem, div_annul
//                          divider interface
//   op_a, op_b             captured operands for both units
//   stallreq               hold pipeline at EX
//   result, result_valid   final result to EX
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned XLEN    = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              mul_start,
    output logic              mul_a_signed,
    output logic              mul_b_signed,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              div_start,
    output logic              div_signed,
    input  logic              div_done,
    input  logic [XLEN-1:0]   div_quot,
    input  logic [XLEN-1:0]   div_rem,
    output logic              div_annul,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic              stallreq,
    output logic [XLEN-1:0]   result,
    output logic              result_valid
);

    localparam logic [3:0] L_LAT = 4'(MUL_LAT);

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_result;
    logic [2:0]      r_op;
    logic [3:0]      r_cnt;
    logic            r_first;

    logic            w_accept;
    logic            w_is_special;
    logic [XLEN-1:0] w_special_result;
    logic [XLEN-1:0] w_mul_word;
    logic [XLEN-1:0] w_div_word;
    logic            w_unused;

    assign w_unused = ^{stall[5:3], stall[1:0]};

    md_special_case #(.XLEN(XLEN)) u_special (
        .op             (op),
        .a              (a),
        .b              (b),
        .is_special     (w_is_special),
        .special_result (w_special_result)
    );

    assign w_accept   = (r_state == ST_IDLE) && ex_valid && !flush;
    assign w_mul_word = (r_op == OP_MUL) ? mul_result[XLEN-1:0]
                                         : mul_result[2*XLEN-1:XLEN];
    assign w_div_word = r_op[1] ? div_rem : div_quot;

    assign op_a   = r_op_a;
    assign op_b   = r_op_b;
    assign result = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        stallreq     = 1'b0;
        mul_start    = 1'b0;
        mul_a_signed = 1'b0;
        mul_b_signed = 1'b0;
        div_start    = 1'b0;
        div_signed   = 1'b0;
        div_annul    = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    stallreq = 1'b1;
                    if (w_is_special) begin
                        w_next = ST_DONE;
                    end else if (op[2]) begin
                        w_next = ST_DIV_WAIT;
                    end else begin
                        w_next = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                stallreq     = !flush;
                mul_start    = r_first && !flush;
                mul_a_signed = (r_op == OP_MUL) || (r_op == OP_MULH) ||
                               (r_op == OP_MULHSU);
                mul_b_signed = (r_op == OP_MUL) || (r_op == OP_MULH);
                if (flush) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DIV_WAIT: begin
                stallreq   = !flush;
                div_start  = r_first && !flush;
                div_signed = (r_op == OP_DIV) || (r_op == OP_REM);
                div_annul  = flush;
                if (flush) begin
                    w_next = ST_IDLE;
                end else if (div_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (flush || !stall[2]) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The counter is loaded at accept so that it reads MUL_LAT in the
    // mul_start cycle and reaches zero exactly when the product is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_first  <= 1'b0;
        end else begin
            r_first <= 1'b0;
            if (w_accept) begin
                r_op_a  <= a;
                r_op_b  <= b;
                r_op    <= op;
                r_cnt   <= L_LAT;
                r_first <= !w_is_special;
                if (w_is_special) begin
                    r_result <= w_special_result;
                end
            end else if (r_state == ST_MUL_WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (!flush) begin
                    r_result <= w_mul_word;
                end
            end else if ((r_state == ST_DIV_WAIT) && div_done && !flush) begin
                r_result <= w_div_word;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int unsigned LAT = 2;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mul_start, mul_a_signed, mul_b_signed;
    logic [63:0] mul_result = JUNK;
    logic        div_start, div_signed, div_annul;
    logic        div_done = 1'b0;
    logic [31:0] div_quot = '0;
    logic [31:0] div_rem = '0;
    logic [31:0] op_a, op_b, result;
    logic        stallreq, result_valid;

    int n_err = 0;
    int n_chk = 0;

    muldiv_sched #(.MUL_LAT(LAT), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .op           (op),
        .a            (a),
        .b            (b),
        .mul_start    (mul_start),
        .mul_a_signed (mul_a_signed),
        .mul_b_signed (mul_b_signed),
        .mul_result   (mul_result),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_done     (div_done),
        .div_quot     (div_quot),
        .div_rem      (div_rem),
        .div_annul    (div_annul),
        .op_a         (op_a),
        .op_b         (op_b),
        .stallreq     (stallreq),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_mul(input string tag, input logic [2:0] f3,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic [63:0] prod, input logic [31:0] exp_r,
                           input logic exp_as, input logic exp_bs);
        ex_valid = 1'b1; op = f3; a = va; b = vb;
        #1;
        chk({tag, " accept stallreq"}, stallreq, 1);
        chk({tag, " accept mul_start"}, mul_start, 0);
        tick();
        ex_valid = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        #1;
        chk({tag, " mul_start"}, mul_start, 1);
        chk({tag, " op_a"}, op_a, va);
        chk({tag, " op_b"}, op_b, vb);
        chk({tag, " a_signed"}, mul_a_signed, exp_as);
        chk({tag, " b_signed"}, mul_b_signed, exp_bs);
        for (int k = 1; k <= int'(LAT); k++) begin
            tick();
            if (k == int'(LAT)) mul_result = prod;
            #1;
            chk({tag, " wait stallreq"}, stallreq, 1);
            chk({tag, " wait mul_start"}, mul_start, 0);
        end
        tick();
        mul_result = JUNK;
        #1;
        chk({tag, " done valid"}, result_valid, 1);
        chk({tag, " result"}, result, exp_r);
        chk({tag, " done stallreq"}, stallreq, 0);
        tick();
        #1;
        chk({tag, " idle valid"}, result_valid, 0);
    endtask

    task automatic run_special(input string tag, input logic [2:0] f3,
                               input logic [31:0] va, input logic [31:0] vb,
                               input logic [31:0] exp_r);
        ex_valid = 1'b1; op = f3; a = va; b = vb;
        #1;
        chk({tag, " accept stallreq"}, stallreq, 1);
        tick();
        ex_valid = 1'b0;
        #1;
        chk({tag, " div_start"}, div_start, 0);
        chk({tag, " done valid"}, result_valid, 1);
        chk({tag, " result"}, result, exp_r);
        tick();
        #1;
        chk({tag, " idle valid"}, result_valid, 0);
    endtask

    initial begin
        int bad;
        // Reset state
        #1;
        chk("reset stallreq", stallreq, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset op_a", op_a, 0);
        chk("reset result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Multiplies
        run_mul("mul", OP_MUL, 32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA,
                32'hFFFF_FFFA, 1'b1, 1'b1);
        run_mul("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_mul("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,
                64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Divide special cases
        run_special("div0", OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_special("rem0", OP_REM, 32'd7, 32'd0, 32'd7);
        run_special("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_special("removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush beats ex_valid in IDLE
        ex_valid = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd4; b = 32'd4;
        #1;
        chk("flush idle stallreq", stallreq, 0);
        tick();
        ex_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush idle mul_start", mul_start, 0);
        chk("flush idle stallreq2", stallreq, 0);

        // DIVU 100/7 through the divider, then held by stall[2]
        tick();
        ex_valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        #1;
        chk("divu accept stallreq", stallreq, 1);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("divu div_start", div_start, 1);
        chk("divu div_signed", div_signed, 0);
        chk("divu stallreq", stallreq, 1);
        bad = 0;
        for (int k = 2; k <= 33; k++) begin
            tick();
            #1;
            if (stallreq !== 1'b1 || div_start !== 1'b0 || result_valid !== 1'b0) bad++;
        end
        chk("divu wait cycles bad", bad, 0);
        tick();
        div_done = 1'b1; div_quot = 32'd14; div_rem = 32'd2;
        #1;
        chk("divu done-cycle stallreq", stallreq, 1);
        tick();
        div_done = 1'b0; div_quot = 32'h5555_5555; div_rem = 32'h5555_5555;
        stall = 6'b000100;
        #1;
        chk("divu valid", result_valid, 1);
        chk("divu result", result, 14);
        chk("divu done stallreq", stallreq, 0);
        tick();
        ex_valid = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
        #1;
        chk("hold1 valid", result_valid, 1);
        chk("hold1 result", result, 14);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("hold2 valid", result_valid, 1);
        chk("hold2 result", result, 14);
        chk("hold2 op_a", op_a, 100);
        chk("hold2 mul_start", mul_start, 0);
        tick();
        stall = '0;
        #1;
        chk("hold3 valid", result_valid, 1);
        tick();
        #1;
        chk("release valid", result_valid, 0);
        chk("release stallreq", stallreq, 0);

        // DIV 100/7 flushed in DIV_WAIT
        ex_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("divf div_start", div_start, 1);
        chk("divf div_signed", div_signed, 1);
        for (int k = 2; k <= 4; k++) tick();
        tick();
        flush = 1'b1;
        #1;
        chk("divf annul", div_annul, 1);
        chk("divf stallreq", stallreq, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("divf annul off", div_annul, 0);
        chk("divf idle valid", result_valid, 0);
        div_done = 1'b1; div_quot = 32'd99;
        tick();
        div_done = 1'b0;
        #1;
        chk("stale div_done valid", result_valid, 0);
        chk("stale div_done stallreq", stallreq, 0);

        // Asynchronous reset in MUL_WAIT
        tick();
        ex_valid = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd5;
        tick();
        ex_valid = 1'b0;
        tick();
        #1;
        chk("pre-rst stallreq", stallreq, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst stallreq", stallreq, 0);
        chk("rst mul_start", mul_start, 0);
        chk("rst a_signed", mul_a_signed, 0);
        chk("rst op_a", op_a, 0);
        chk("rst op_b", op_b, 0);
        chk("rst result", result, 0);
        chk("rst valid", result_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_mul("mul2x3", OP_MUL, 32'd2, 32'd3, 64'd6, 32'd6, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
Scheduler for the M-extension multiply/divide resources in the EX stage. Accepts one M-ext op from EX and captures its operands. Sequences either the fixed-latency multiplier or the handshake-based iterative divider, and resolves divide special cases without launching the divider. Drives the EX stall request and holds the result until the pipeline advances past EX (stall[2] low).

Parameters:
MUL_LAT, 2, cycles from mul_start to valid mul_result (1..15)
XLEN, 32, operand/result width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall  in  6  pipeline stall vector; bit 2 = EX held
flush  in  1  kill in-flight M-ext op
ex_valid  in  1  M-ext op present in EX
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 value
b  in  XLEN  rs2 value
mul_start  out  1  one-cycle start pulse to multiplier
mul_a_signed, mul_b_signed  out  1 each  operand signedness to multiplier
mul_result  in  2*XLEN  product, valid MUL_LAT cycles after mul_start
div_start  out  1  one-cycle start pulse to divider
div_signed  out  1  signed divide
div_done  in  1  one-cycle pulse; quotient/remainder valid
div_quot, div_rem  in  XLEN each  divider results
div_annul  out  1  one-cycle abort pulse to divider
op_a, op_b  out  XLEN each  captured operands, shared by both units
stallreq  out  1  hold pipeline at EX
result  out  XLEN  final result
result_valid  out  1  result presented to EX

Behaviour:
- Reset (async, any state): state IDLE. All outputs 0. Operand, op and result registers cleared. Latency counter 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE:
  - ex_valid & !flush: capture a, b, op into op_a/op_b/op_r. stallreq=1 combinationally this cycle.
  - If op is a div/rem (op[2]=1) and a special case applies: load result and go to DONE.
  - Otherwise a div/rem goes to DIV_WAIT; a multiply goes to MUL_WAIT.
  - Only IDLE accepts new ops.
- Special cases:
  - b==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - Signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - No div_start is issued.
- MUL_WAIT:
  - First cycle: mul_start=1; counter loads MUL_LAT. Counter decrements each later cycle.
  - On the cycle the counter reaches 0: latch result. MUL takes mul_result[31:0]; MULH/MULHSU/MULHU take [63:32]. Go to DONE.
  - Signedness: MUL/MULH → both signed; MULHSU → a signed only; MULHU → none.
  - Latency: accept at T, mul_start at T+1, sample at T+1+MUL_LAT, DONE at T+2+MUL_LAT.
- DIV_WAIT:
  - First cycle: div_start=1. div_signed = (op==DIV|op==REM).
  - On div_done: latch div_quot (DIV/DIVU) or div_rem (REM/REMU), then go to DONE. No timeout.
- stallreq = 1 in IDLE-with-accept, MUL_WAIT, DIV_WAIT; 0 in DONE and whenever flush=1.
- DONE:
  - result_valid=1; result stable.
  - stall[2]=0 → IDLE next cycle. stall[2]=1 → stay in DONE and hold result.
  - ex_valid is ignored in DONE; the same instruction is never re-issued.
- op_a/op_b stay constant from accept until leaving DONE.
- Flush:
  - Any state → IDLE next cycle; result_valid drops.
  - In DIV_WAIT: div_annul=1 for that cycle.
  - Flush beats ex_valid in IDLE, and beats div_done or counter expiry in the same cycle (result discarded).
- Stale unit outputs (div_done, mul_result) while in IDLE or DONE are ignored.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (OP_MUL..OP_REMU).
  - State enum encoding.
  - Special-case constants DIV0_QUOT (all ones) and INT_MIN.
- One sub-module, md_special_case (combinational):
  - Inputs: op, a, b.
  - Outputs: is_special and special_result.
- FSM, counter and result register stay in muldiv_sched.

Test Plan:
1. MUL_LAT=2; MUL a=3, b=0xFFFFFFFE, accept at T → mul_start at T+1; stallreq high T..T+3; result 0xFFFFFFFA; result_valid at T+4; IDLE at T+5 with stall[2]=0.
2. MULHU a=b=0xFFFFFFFF, mul_result=0xFFFFFFFE00000001 → result 0xFFFFFFFE, mul_a_signed=mul_b_signed=0. MULHSU a=0xFFFFFFFF, b=2 → mul_a_signed=1, mul_b_signed=0.
3. DIV 7/0 → no div_start; DONE at T+1; result 0xFFFFFFFF. REM 7/0 → 7. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0.
4. DIVU 100/7, div_done pulsed 33 cycles after div_start with quot=14 → stallreq high until the div_done cycle; result 14. Then hold stall[2]=1 for 3 cycles → state stays DONE, result stays 14; release → IDLE.
5. DIV 100/7 in DIV_WAIT, flush at cycle 5 → div_annul one-cycle pulse; stallreq 0; IDLE next cycle. A later div_done pulse → result_valid stays 0.
6. rst asserted mid-MUL_WAIT (asynchronously, between edges) → all outputs 0 immediately. After release, the next MUL 2×3 → result 6 with normal latency.
